mfp_eic_input_conditioner: RTL and testbench

//  Per-channel interrupt input conditioner; sits directly upstream of the AHB-Lite EIC.

---
 rtl/mfp_eic_input_conditioner.sv | 83 ++++++++
 tb/tb_mfp_eic_input_conditioner.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mfp_eic_input_conditioner.sv
// Interrupt input conditioner for the EIC. Each raw request line is synchronised,
// optionally inverted and glitch-filtered, then output as a clean level with edge pulses.
module mfp_eic_input_conditioner #(
    parameter int CHANNELS     = 32,
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_WIDTH = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [CHANNELS-1:0]     irq_raw,
    input  logic [CHANNELS-1:0]     invert,
    input  logic [CHANNELS-1:0]     filter_en,
    input  logic [FILTER_WIDTH-1:0] filter_len,
    output logic [CHANNELS-1:0]     irq_out,
    output logic [CHANNELS-1:0]     irq_rise,
    output logic [CHANNELS-1:0]     irq_fall
);

    logic [CHANNELS-1:0] sync_reg [SYNC_STAGES];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= irq_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic                    x;
            logic                    s_reg;
            logic                    s_next;
            logic                    rise_reg;
            logic                    fall_reg;
            logic [FILTER_WIDTH-1:0] cnt_reg;
            logic [FILTER_WIDTH-1:0] cnt_next;

            assign x = sync_reg[SYNC_STAGES-1][gi] ^ invert[gi];

            // The >= compare lets a lowered filter_len take effect on the next
            // differing cycle; the counter saturates at the threshold, so it never wraps.
            always_comb begin
                s_next   = s_reg;
                cnt_next = '0;
                if (!filter_en[gi]) begin
                    s_next = x;
                end else if (x != s_reg) begin
                    if (cnt_reg >= filter_len) begin
                        s_next = x;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    s_reg    <= 1'b0;
                    cnt_reg  <= '0;
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                end else begin
                    s_reg    <= s_next;
                    cnt_reg  <= cnt_next;
                    rise_reg <= ~s_reg & s_next;
                    fall_reg <= s_reg & ~s_next;
                end
            end

            assign irq_out[gi]  = s_reg;
            assign irq_rise[gi] = rise_reg;
            assign irq_fall[gi] = fall_reg;
        end
    endgenerate

endmodule

// File: tb/tb_mfp_eic_input_conditioner.sv
// Scoreboard bench for mfp_eic_input_conditioner: stimulus queues expected edge pulses,
// a negedge monitor pops and compares them; levels are checked directly.
module tb_mfp_eic_input_conditioner;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] irq_raw;
    logic [31:0] invert;
    logic [31:0] filter_en;
    logic [3:0]  filter_len;
    logic [31:0] irq_out;
    logic [31:0] irq_rise;
    logic [31:0] irq_fall;

    mfp_eic_input_conditioner #(
        .CHANNELS    (32),
        .SYNC_STAGES (2),
        .FILTER_WIDTH(4)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .irq_raw   (irq_raw),
        .invert    (invert),
        .filter_en (filter_en),
        .filter_len(filter_len),
        .irq_out   (irq_out),
        .irq_rise  (irq_rise),
        .irq_fall  (irq_fall)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int ch;
        bit rise;
    } ev_t;

    ev_t q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic push(input int ch, input bit rise, input int at);
        ev_t e;
        e.cyc  = at;
        e.ch   = ch;
        e.rise = rise;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Monitor: every rise/fall pulse must match the head of the expected queue.
    always @(negedge CLK) begin
        for (int ch = 0; ch < 32; ch++) begin
            if (irq_rise[ch] && irq_fall[ch]) begin
                n_checks++;
                n_fail++;
                $display("FAIL both_pulses ch%0d: rise and fall high together (cycle %0d)", ch, cyc);
            end else if (irq_rise[ch] || irq_fall[ch]) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse ch%0d: got %s at cycle %0d, expected none",
                             ch, irq_rise[ch] ? "rise" : "fall", cyc);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    if (e.ch != ch || e.rise != irq_rise[ch] || e.cyc != cyc) begin
                        n_fail++;
                        $display("FAIL pulse: got ch%0d %s cycle %0d, expected ch%0d %s cycle %0d",
                                 ch, irq_rise[ch] ? "rise" : "fall", cyc,
                                 e.ch, e.rise ? "rise" : "fall", e.cyc);
                    end else begin
                        $display("ok   pulse ch%0d %s cycle %0d", ch, e.rise ? "rise" : "fall", cyc);
                    end
                end
            end
        end
    end

    initial begin
        int k;
        RESET      = 1'b1;
        irq_raw    = 32'h0000_0004;
        invert     = 32'h0000_0004;
        filter_en  = 32'h0000_0004;
        filter_len = 4'd4;

        tick(3);
        check("reset_out", irq_out, 32'h0);
        check("reset_rise", irq_rise, 32'h0);
        check("reset_fall", irq_fall, 32'h0);
        RESET = 1'b0;
        tick(8);
        check("invert_idle_out", irq_out, 32'h0);

        // Inverted channel 2: raw 1->0 means active, filtered with N=4 -> 7 clocks.
        k = cyc; irq_raw[2] = 1'b0; push(2, 1'b1, k + 7);
        tick(10);
        check("invert_active_out", irq_out, 32'h0000_0004);
        k = cyc; irq_raw[2] = 1'b1; push(2, 1'b0, k + 7);
        tick(10);

        // Bypass on channel 0: 3 clocks.
        k = cyc; irq_raw[0] = 1'b1; push(0, 1'b1, k + 3);
        tick(6);
        check("bypass_out", irq_out, 32'h0000_0001);
        k = cyc; irq_raw[0] = 1'b0; push(0, 1'b0, k + 3);
        tick(6);

        // N=3 on channel 5: 3-cycle pulse is rejected, 4-cycle pulse passes.
        filter_len = 4'd3; filter_en[5] = 1'b1;
        irq_raw[5] = 1'b1; tick(3); irq_raw[5] = 1'b0;
        tick(10);
        check("short_pulse_out", irq_out, 32'h0);
        k = cyc; irq_raw[5] = 1'b1; push(5, 1'b1, k + 6);
        tick(4); irq_raw[5] = 1'b0; push(5, 1'b0, k + 10);
        tick(14);

        // N=4 glitch restart: high 3, low 1, high 5.
        filter_len = 4'd4;
        irq_raw[5] = 1'b1; tick(3);
        irq_raw[5] = 1'b0; tick(1);
        k = cyc; irq_raw[5] = 1'b1; push(5, 1'b1, k + 7);
        tick(5); irq_raw[5] = 1'b0; push(5, 1'b0, k + 12);
        tick(14);

        // Reset mid-count: N=7, channel 9 count reaches 5, channel 0 held high.
        filter_len = 4'd7; filter_en[9] = 1'b1;
        k = cyc; irq_raw[0] = 1'b1; push(0, 1'b1, k + 3);
        tick(4);
        k = cyc; irq_raw[9] = 1'b1;
        tick(7);
        RESET = 1'b1;
        tick(1);
        check("midreset_out", irq_out, 32'h0);
        check("midreset_rise", irq_rise, 32'h0);
        check("midreset_fall", irq_fall, 32'h0);
        k = cyc; RESET = 1'b0;
        push(0, 1'b1, k + 3);
        push(9, 1'b1, k + 10);
        tick(12);
        check("after_reset_out", irq_out, 32'h0000_0201);
        k = cyc; irq_raw[0] = 1'b0; irq_raw[9] = 1'b0;
        push(0, 1'b0, k + 3);
        push(9, 1'b0, k + 10);
        tick(12);

        // All 32 channels at once, N=2 -> 5 clocks.
        filter_len = 4'd2; filter_en = 32'hFFFF_FFFF;
        k = cyc; irq_raw = ~irq_raw;
        for (int ch = 0; ch < 32; ch++) push(ch, 1'b1, k + 5);
        tick(8);
        check("parallel_out", irq_out, 32'hFFFF_FFFF);
        k = cyc; irq_raw = ~irq_raw;
        for (int ch = 0; ch < 32; ch++) push(ch, 1'b0, k + 5);
        tick(8);
        check("parallel_low", irq_out, 32'h0);

        check("queue_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
